// File: rtl/lc3_pipe_ctrl.sv
// rtl/lc3_pipe_ctrl.sv - LC3 pipeline stage enables, data-memory FSM and branch bubble control
// Optional PERF_CNT_EN adds the stall_cycles counter output.
module lc3_pipe_ctrl #(
    parameter logic [1:0] MEM_IDLE = 2'd3,
    parameter logic [1:0] MEM_RD   = 2'd0,
    parameter logic [1:0] MEM_IND  = 2'd1,
    parameter logic [1:0] MEM_WR   = 2'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic [15:0] ir_exec,
    input  logic [2:0]  psr,
    input  logic        complete_data,
    output logic        enable_updatepc,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic [1:0]  mem_state
`ifdef PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_STI = 4'b1011;

    logic [1:0] mem_next;
    logic [1:0] br_cnt;
    logic [1:0] br_next;
    logic       dec_valid;
    logic       exec_valid;

    logic [3:0] op_dec;
    logic [3:0] op_exec;
    logic       exec_is_load;
    logic       exec_is_ind;
    logic       exec_is_store;
    logic       exec_is_mem;
    logic       exec_is_jmp;
    logic       dec_is_br;
    logic       mem_trig;
    logic       br_trig;
    logic       unused_bits;

    assign op_dec  = ir[15:12];
    assign op_exec = ir_exec[15:12];

    assign exec_is_load  = (op_exec == OP_LD)  || (op_exec == OP_LDR);
    assign exec_is_ind   = (op_exec == OP_LDI) || (op_exec == OP_STI);
    assign exec_is_store = (op_exec == OP_ST)  || (op_exec == OP_STR);
    assign exec_is_mem   = exec_is_load || exec_is_ind || exec_is_store;
    assign exec_is_jmp   = (op_exec == OP_JMP);
    assign dec_is_br     = (op_dec == OP_BR) || (op_dec == OP_JMP);

    // A memory op waiting in execute wins over a branch waiting in decode.
    assign mem_trig = (mem_state == MEM_IDLE) && exec_valid && exec_is_mem;
    assign br_trig  = (mem_state == MEM_IDLE) && (br_cnt == 2'd0) && dec_valid
                      && dec_is_br && !mem_trig;

    assign unused_bits = ^{ir[11:0], ir_exec[8:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_state  <= MEM_IDLE;
            br_cnt     <= 2'd0;
            dec_valid  <= 1'b0;
            exec_valid <= 1'b0;
        end else begin
            mem_state  <= mem_next;
            br_cnt     <= br_next;
            dec_valid  <= enable_decode;
            exec_valid <= enable_execute;
        end
    end

    always_comb begin
        mem_next = mem_state;
        br_next  = br_cnt;
        case (mem_state)
            MEM_IDLE: begin
                if (mem_trig) begin
                    if (exec_is_load) begin
                        mem_next = MEM_RD;
                    end else if (exec_is_ind) begin
                        mem_next = MEM_IND;
                    end else begin
                        mem_next = MEM_WR;
                    end
                end else begin
                    case (br_cnt)
                        2'd2:    br_next = 2'd1;
                        2'd1:    br_next = 2'd0;
                        2'd0:    br_next = br_trig ? 2'd2 : 2'd0;
                        default: br_next = 2'd0;
                    endcase
                end
            end
            MEM_RD: begin
                if (complete_data) begin
                    mem_next = MEM_IDLE;
                end
            end
            MEM_IND: begin
                if (complete_data) begin
                    mem_next = (op_exec == OP_LDI) ? MEM_RD : MEM_WR;
                end
            end
            MEM_WR: begin
                if (complete_data) begin
                    mem_next = MEM_IDLE;
                end
            end
            default: mem_next = MEM_IDLE;
        endcase
    end

    always_comb begin
        enable_updatepc  = 1'b0;
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        br_taken         = 1'b0;
        if (rst) begin
            if (mem_state != MEM_IDLE) begin
                // Only a completed data read retires a register write.
                enable_writeback = (mem_state == MEM_RD) && complete_data;
            end else if (mem_trig) begin
                enable_writeback = 1'b0;
            end else if (br_cnt == 2'd2) begin
                enable_writeback = exec_valid;
            end else if (br_cnt == 2'd1) begin
                enable_updatepc  = 1'b1;
                enable_fetch     = 1'b1;
                enable_writeback = exec_valid;
                br_taken         = exec_is_jmp || (|(ir_exec[11:9] & psr));
            end else if (br_trig) begin
                enable_execute   = 1'b1;
                enable_writeback = exec_valid;
            end else begin
                enable_updatepc  = 1'b1;
                enable_fetch     = 1'b1;
                enable_decode    = 1'b1;
                enable_execute   = 1'b1;
                enable_writeback = exec_valid;
            end
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= 16'h0000;
        end else if (!enable_fetch && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'h0001;
        end
    end
`endif

endmodule
